cgp_gene_mutator: RTL and testbench
===================================

Name: cgp_gene_mutator

Overview:
Generates the genotype that CGP node evaluators consume: the per-node mux-select pairs and function codes.
- On a start pulse, copies a parent chromosome into an internal child register.
- Rewrites MUT_COUNT randomly chosen genes using an internal LFSR, rejecting any value an evaluator node could not legally decode.
- Sits between the evolution controller (which supplies the parent) and the node array (which consumes `child`).

Parameters:
- NODE_COUNT, 8, number of nodes in the chromosome.
- CHOICES, 9, number of legal mux inputs; a legal select is < CHOICES.
- SEL_BIT, 4, width of each mux select field.
- FUNC_BIT, 2, width of the function field.
- FUNC_COUNT, 4, number of legal function codes; a legal code is < FUNC_COUNT.
- MUT_COUNT, 2, number of gene writes per offspring; range 1..15.
- LFSR_SEED, 16'hACE1, LFSR value after reset; must be nonzero.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to build an offspring; sampled only in IDLE.
- parent  in  NODE_COUNT*GENE_W  source chromosome; sampled on the accepted start cycle.
- seed_load  in  1  load `seed` into the LFSR; honoured only in IDLE.
- seed  in  16  new LFSR value.
- busy  out  1  high from the cycle after start is accepted until `done`.
- done  out  1  one-cycle pulse when `child` is final.
- child  out  NODE_COUNT*GENE_W  registered offspring chromosome.

Behaviour:
- Gene packing:
  - GENE_W = 2*SEL_BIT+FUNC_BIT.
  - Node i occupies bits [i*GENE_W +: GENE_W].
  - Inside a gene, from LSB upward: sel0, sel1, func.
- Reset (rst=0 at a clock edge):
  - state=IDLE, busy=0, done=0, child=0, lfsr=LFSR_SEED, mut counter=0.
  - Reset takes priority in every state, including mid-mutation; any partial child is discarded.
- LFSR:
  - 16-bit Galois LFSR, taps mask 16'hB400.
  - Advances exactly once per clock in PICK. It holds in all other states.
- Seed loading:
  - seed_load in IDLE sets lfsr=seed, or 16'hACE1 if seed==0.
  - If seed_load and start arrive in the same cycle, the seed is loaded first; the new seed takes effect in the first PICK cycle.
  - seed_load outside IDLE is ignored.
- IDLE:
  - On start=1: child<=parent, counter<=0, busy<=1, go to PICK.
  - start while busy is ignored.
- PICK (one candidate per cycle, drawn from the current lfsr value):
  - idx = lfsr[IDX_W-1:0], with IDX_W = clog2(NODE_COUNT) and minimum 1.
  - field = lfsr[IDX_W+1:IDX_W] (0=sel0, 1=sel1, 2=func).
  - val = lfsr[15 -: SEL_BIT]; for func, its low FUNC_BIT bits.
  - The candidate is rejected (stay in PICK) if any of these hold: idx>=NODE_COUNT, field==3, a select val>=CHOICES, or a func val>=FUNC_COUNT.
  - Otherwise register the candidate and go to APPLY.
- APPLY:
  - Write val into the chosen field of child and increment the counter.
  - If counter+1==MUT_COUNT go to DONE, else return to PICK.
- DONE:
  - done=1 for exactly one cycle, busy=0, go to IDLE.
- Latency: minimum start-to-done is 2*MUT_COUNT+1 cycles. Rejections add one cycle each.
- Termination: the maximal-length LFSR guarantees a legal candidate eventually appears.
- Outputs: child holds its value until the next accepted start or reset.
- Repeat writes: the same gene may be hit twice; the last write wins. Invariant: at most MUT_COUNT genes differ from parent.
- Legality: all select fields written by the block are < CHOICES. Parent fields that are never touched pass through unchanged, even if they are illegal.

Optional Feature:
- Macro: CGP_MUT_FORCE_CHANGE_EN.
- Defined: PICK also rejects a candidate whose val equals the current field value in child. Every APPLY therefore changes a bit.
- Undefined: no such check, and a write may be a no-op.

Decomposition:
- Package cgp_pkg holds:
  - the GENE_W function;
  - the field encodings FIELD_SEL0/FIELD_SEL1/FIELD_FUNC;
  - the LFSR taps constant 16'hB400 and the default seed;
  - the state enum IDLE/PICK/APPLY/DONE.
- Sub-module cgp_lfsr16 holds the LFSR register, enable, and load/zero-substitution. It is reused by the other CGP random sources.

Test Plan:
- Parent all-zero, seed 16'h0001, start → done after ≥5 cycles; ≤2 genes nonzero; every sel field <9; every func field <4.
- Same seed and same parent, run twice → the two child values are bit-identical.
- Parent all-zero, assert rst=0 on the second PICK cycle → next cycle busy=0, done=0, child=0; a following start completes normally.
- start re-pulsed on every cycle while busy → exactly one done pulse per accepted start; child is unaffected by the extra pulses.
- seed_load with seed=0 in IDLE → lfsr=16'hACE1; the run matches a run seeded with 16'hACE1.
- With CGP_MUT_FORCE_CHANGE_EN defined, MUT_COUNT=1, parent all-zero, 100 runs → child differs from parent in every run.

Source files
------------

// File: rtl/cgp_gene_mutator_pkg.sv
// cgp_pkg: shared gene layout helper, field codes, LFSR constants and mutator states
package cgp_pkg;

    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    localparam logic [1:0] FIELD_SEL0 = 2'd0;
    localparam logic [1:0] FIELD_SEL1 = 2'd1;
    localparam logic [1:0] FIELD_FUNC = 2'd2;

    typedef enum logic [1:0] {IDLE, PICK, APPLY, DONE} state_e;

    function automatic int gene_w(input int sel_bit, input int func_bit);
        return 2 * sel_bit + func_bit;
    endfunction

endpackage

// File: rtl/cgp_gene_mutator_lfsr.sv
// cgp_lfsr16: 16-bit Galois LFSR with enable and zero-safe load, shared by CGP random sources
module cgp_lfsr16
    import cgp_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    input  logic        load_i,
    input  logic [15:0] load_val_i,
    output logic [15:0] q_o
);

    logic [15:0] lfsr_q, lfsr_d;

    assign lfsr_d = load_i ? ((load_val_i == 16'h0) ? LFSR_DEFAULT_SEED : load_val_i)
                  : en_i   ? ({1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0))
                  : lfsr_q;
    assign q_o = lfsr_q;

    // state register; an all-zero load is replaced so the sequence never locks up
    always_ff @(posedge clk) begin
        if (!rst) lfsr_q <= SEED;
        else      lfsr_q <= lfsr_d;
    end

endmodule

// File: rtl/cgp_gene_mutator.sv
// cgp_gene_mutator: copies a parent chromosome and rewrites MUT_COUNT legal genes; CGP_MUT_FORCE_CHANGE_EN rejects no-op writes
module cgp_gene_mutator
    import cgp_pkg::*;
#(
    parameter int          NODE_COUNT = 8,
    parameter int          CHOICES    = 9,
    parameter int          SEL_BIT    = 4,
    parameter int          FUNC_BIT   = 2,
    parameter int          FUNC_COUNT = 4,
    parameter int          MUT_COUNT  = 2,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    localparam int         GENE_W     = gene_w(SEL_BIT, FUNC_BIT)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [NODE_COUNT*GENE_W-1:0] parent,
    input  logic                         seed_load,
    input  logic [15:0]                  seed,
    output logic                         busy,
    output logic                         done,
    output logic [NODE_COUNT*GENE_W-1:0] child
);

    localparam int IDX_W = (NODE_COUNT > 1) ? $clog2(NODE_COUNT) : 1;

    state_e                       state_q, state_d;
    logic [3:0]                   cnt_q, cnt_d;
    logic [NODE_COUNT*GENE_W-1:0] child_q, child_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [1:0]                   field_q, field_d;
    logic [SEL_BIT-1:0]           val_q, val_d;
    logic [15:0]                  lfsr;
    logic [IDX_W-1:0]             cand_idx;
    logic [1:0]                   cand_field;
    logic [SEL_BIT-1:0]           cand_val, wr_val;
    logic                         cand_legal, cand_ok;
    logic                         unused_lfsr;

    cgp_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .en_i      (state_q == PICK),
        .load_i    (seed_load && state_q == IDLE),
        .load_val_i(seed),
        .q_o       (lfsr)
    );

    assign unused_lfsr = ^lfsr;
    assign cand_idx    = lfsr[IDX_W-1:0];
    assign cand_field  = lfsr[IDX_W+1:IDX_W];
    assign cand_val    = lfsr[15 -: SEL_BIT];
    assign wr_val      = (cand_field == FIELD_FUNC) ? SEL_BIT'(cand_val[FUNC_BIT-1:0]) : cand_val;
    assign cand_legal  = (32'(cand_idx) < NODE_COUNT) && (cand_field != 2'd3)
                      && ((cand_field == FIELD_FUNC) ? (32'(wr_val) < FUNC_COUNT) : (32'(cand_val) < CHOICES));

`ifdef CGP_MUT_FORCE_CHANGE_EN
    logic [GENE_W-1:0]  cur_gene;
    logic [SEL_BIT-1:0] cur_val;
    assign cur_gene = GENE_W'(child_q >> (32'(cand_idx) * GENE_W));
    assign cur_val  = (cand_field == FIELD_SEL0) ? cur_gene[SEL_BIT-1:0]
                    : (cand_field == FIELD_SEL1) ? cur_gene[2*SEL_BIT-1:SEL_BIT]
                    : SEL_BIT'(cur_gene[GENE_W-1 -: FUNC_BIT]);
    assign cand_ok  = cand_legal && (wr_val != cur_val);
`else
    assign cand_ok  = cand_legal;
`endif

    assign busy  = (state_q == PICK) || (state_q == APPLY);
    assign done  = (state_q == DONE);
    assign child = child_q;

    // state and datapath registers; reset discards any partially built child
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            child_q <= '0;
            idx_q   <= '0;
            field_q <= '0;
            val_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            child_q <= child_d;
            idx_q   <= idx_d;
            field_q <= field_d;
            val_q   <= val_d;
        end
    end

    // next state: copy parent, draw candidates until one is legal, write it, repeat MUT_COUNT times
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        child_d = child_q;
        idx_d   = idx_q;
        field_d = field_q;
        val_d   = val_q;
        case (state_q)
            IDLE: if (start) begin
                child_d = parent;
                cnt_d   = '0;
                state_d = PICK;
            end
            PICK: if (cand_ok) begin
                idx_d   = cand_idx;
                field_d = cand_field;
                val_d   = wr_val;
                state_d = APPLY;
            end
            APPLY: begin
                for (int i = 0; i < NODE_COUNT; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        if (field_q == FIELD_SEL0)      child_d[i*GENE_W +: SEL_BIT] = val_q;
                        else if (field_q == FIELD_SEL1) child_d[i*GENE_W+SEL_BIT +: SEL_BIT] = val_q;
                        else                            child_d[i*GENE_W+2*SEL_BIT +: FUNC_BIT] = val_q[FUNC_BIT-1:0];
                    end
                end
                cnt_d   = cnt_q + 4'd1;
                state_d = (cnt_q == 4'(MUT_COUNT - 1)) ? DONE : PICK;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cgp_gene_mutator.sv
// tb_cgp_gene_mutator: randomized self-checking bench against a gene-array reference model
module tb_cgp_gene_mutator;

    localparam int NODE = 8;
    localparam int CH   = 9;
    localparam int SB   = 4;
    localparam int FB   = 2;
    localparam int FC   = 4;
    localparam int GW   = 2 * SB + FB;
    localparam int W    = NODE * GW;
`ifdef CGP_MUT_FORCE_CHANGE_EN
    localparam int MUT = 1;
`else
    localparam int MUT = 2;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          seed_load = 1'b0;
    logic [W-1:0]  parent = '0;
    logic [15:0]   seed = 16'h0;
    logic          busy, done;
    logic [W-1:0]  child;
    int            total = 0;
    int            bad = 0;
    logic [15:0]   m_lfsr = 16'hACE1;

    always #5 clk = ~clk;

    cgp_gene_mutator #(.MUT_COUNT(MUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .parent   (parent),
        .seed_load(seed_load),
        .seed     (seed),
        .busy     (busy),
        .done     (done),
        .child    (child)
    );

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return (s >> 1) ^ ((s % 2 == 1) ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [W-1:0] rand_chrom();
        return W'({$urandom, $urandom, $urandom});
    endfunction

    // reference: unpack genes, draw candidates from the model LFSR, apply legal ones, repack
    task automatic model_run(input logic [W-1:0] par, output logic [W-1:0] exp, output int picks);
        int g[NODE][3];
        int idx, fld, v, writes;
        bit legal;
        for (int n = 0; n < NODE; n++) begin
            g[n][0] = int'(par[n*GW +: SB]);
            g[n][1] = int'(par[n*GW+SB +: SB]);
            g[n][2] = int'(par[n*GW+2*SB +: FB]);
        end
        writes = 0;
        picks  = 0;
        while (writes < MUT && picks < 5000) begin
            picks++;
            idx = int'(m_lfsr) % 8;
            fld = (int'(m_lfsr) / 8) % 4;
            v   = int'(m_lfsr) / 4096;
            if (fld == 2) v = v % 4;
            m_lfsr = lfsr_next(m_lfsr);
            legal = (idx < NODE) && (fld < 3) && ((fld == 2) ? (v < FC) : (v < CH));
`ifdef CGP_MUT_FORCE_CHANGE_EN
            if (legal && g[idx][fld] == v) legal = 1'b0;
`endif
            if (legal) begin
                g[idx][fld] = v;
                writes++;
            end
        end
        exp = '0;
        for (int n = 0; n < NODE; n++) begin
            exp[n*GW +: SB]      = SB'(g[n][0]);
            exp[n*GW+SB +: SB]   = SB'(g[n][1]);
            exp[n*GW+2*SB +: FB] = FB'(g[n][2]);
        end
    endtask

    task automatic load_seed(input logic [15:0] sv);
        @(negedge clk);
        seed_load = 1'b1;
        seed      = sv;
        @(negedge clk);
        seed_load = 1'b0;
        m_lfsr    = (sv == 16'h0) ? 16'hACE1 : sv;
    endtask

    // drives one start and waits for done; lat counts cycles after the accepting edge, -1 on timeout
    task automatic run_dut(input logic [W-1:0] par, input logic sl, input logic [15:0] sv,
                           output int lat, output logic b1, output logic bd);
        @(negedge clk);
        start     = 1'b1;
        parent    = par;
        seed_load = sl;
        seed      = sv;
        @(negedge clk);
        start     = 1'b0;
        seed_load = 1'b0;
        b1  = busy;
        bd  = 1'b1;
        lat = -1;
        for (int c = 1; c <= 3000; c++) begin
            if (done) begin
                lat = c;
                bd  = busy;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (child !== '0) begin bad++; $display("FAIL reset_child got=%h want=0", child); end
        rst = 1'b1;
        m_lfsr = 16'hACE1;
        @(negedge clk);
    endtask

    task automatic test_zero_parent();
        logic [W-1:0] exp;
        int picks, lat, nz, ill;
        logic b1, bd;
        load_seed(16'h0001);
        model_run('0, exp, picks);
        run_dut('0, 1'b0, 16'h0, lat, b1, bd);
        total++; if (child !== exp) begin bad++; $display("FAIL zero_child got=%h want=%h", child, exp); end
        total++; if (lat != picks + MUT + 1) begin bad++; $display("FAIL zero_latency got=%0d want=%0d", lat, picks + MUT + 1); end
        total++; if (lat < 2 * MUT + 1) begin bad++; $display("FAIL zero_min_latency got=%0d want>=%0d", lat, 2 * MUT + 1); end
        total++; if (b1 !== 1'b1) begin bad++; $display("FAIL zero_busy_first got=%b want=1", b1); end
        nz  = 0;
        ill = 0;
        for (int n = 0; n < NODE; n++) begin
            if (child[n*GW +: GW] != '0) nz++;
            if (int'(child[n*GW +: SB]) >= CH) ill++;
            if (int'(child[n*GW+SB +: SB]) >= CH) ill++;
        end
        total++; if (nz > MUT) begin bad++; $display("FAIL zero_changed_genes got=%0d want<=%0d", nz, MUT); end
        total++; if (ill != 0) begin bad++; $display("FAIL zero_illegal_sel got=%0d want=0", ill); end
    endtask

    task automatic test_random();
        logic [W-1:0] par, exp;
        logic [15:0] sv;
        logic sl, b1, bd;
        int picks, lat, nd;
        for (int r = 0; r < 20; r++) begin
            par = rand_chrom();
            sl  = 1'($urandom_range(0, 1));
            sv  = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom);
            if (sl) m_lfsr = (sv == 16'h0) ? 16'hACE1 : sv;
            model_run(par, exp, picks);
            run_dut(par, sl, sv, lat, b1, bd);
            total++; if (child !== exp) begin bad++; $display("FAIL rand_child run=%0d got=%h want=%h", r, child, exp); end
            total++; if (lat != picks + MUT + 1) begin bad++; $display("FAIL rand_latency run=%0d got=%0d want=%0d", r, lat, picks + MUT + 1); end
            total++; if (b1 !== 1'b1 || bd !== 1'b0) begin bad++; $display("FAIL rand_busy run=%0d got=%b%b want=10", r, b1, bd); end
            nd = 0;
            for (int n = 0; n < NODE; n++) if (child[n*GW +: GW] != par[n*GW +: GW]) nd++;
            total++; if (nd > MUT) begin bad++; $display("FAIL rand_diff run=%0d got=%0d want<=%0d", r, nd, MUT); end
        end
    endtask

    task automatic test_repeat_seed();
        logic [W-1:0] par, exp, c1;
        int picks, lat;
        logic b1, bd;
        par = rand_chrom();
        load_seed(16'h5A3C);
        model_run(par, exp, picks);
        run_dut(par, 1'b0, 16'h0, lat, b1, bd);
        c1 = child;
        load_seed(16'h5A3C);
        run_dut(par, 1'b0, 16'h0, lat, b1, bd);
        total++; if (child !== c1) begin bad++; $display("FAIL repeat_identical got=%h want=%h", child, c1); end
        total++; if (c1 !== exp) begin bad++; $display("FAIL repeat_model got=%h want=%h", c1, exp); end
    endtask

    task automatic test_seed_zero();
        logic [W-1:0] par, exp, c1;
        int picks, lat;
        logic b1, bd;
        par = rand_chrom();
        load_seed(16'h0000);
        model_run(par, exp, picks);
        run_dut(par, 1'b0, 16'h0, lat, b1, bd);
        c1 = child;
        load_seed(16'hACE1);
        run_dut(par, 1'b0, 16'h0, lat, b1, bd);
        total++; if (c1 !== child) begin bad++; $display("FAIL seed_zero_vs_ace1 got=%h want=%h", c1, child); end
        total++; if (c1 !== exp) begin bad++; $display("FAIL seed_zero_model got=%h want=%h", c1, exp); end
        m_lfsr = 16'hACE1;
        model_run(par, exp, picks);
    endtask

    task automatic test_start_while_busy();
        logic [W-1:0] par, exp, c1;
        int picks, ndone, lat;
        par = rand_chrom();
        model_run(par, exp, picks);
        @(negedge clk);
        start  = 1'b1;
        parent = par;
        ndone  = 0;
        lat    = -1;
        for (int c = 1; c <= 3000 && ndone == 0; c++) begin
            @(negedge clk);
            parent    = rand_chrom();
            seed_load = 1'b1;
            seed      = 16'($urandom);
            if (done) begin
                ndone++;
                lat       = c;
                start     = 1'b0;
                seed_load = 1'b0;
            end
        end
        start     = 1'b0;
        seed_load = 1'b0;
        c1 = child;
        repeat (10) begin
            @(negedge clk);
            if (done) ndone++;
        end
        total++; if (ndone != 1) begin bad++; $display("FAIL busy_done_pulses got=%0d want=1", ndone); end
        total++; if (c1 !== exp) begin bad++; $display("FAIL busy_child got=%h want=%h", c1, exp); end
        total++; if (lat != picks + MUT + 1) begin bad++; $display("FAIL busy_latency got=%0d want=%0d", lat, picks + MUT + 1); end
        total++; if (child !== c1) begin bad++; $display("FAIL busy_child_hold got=%h want=%h", child, c1); end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] exp;
        int picks, lat;
        logic b1, bd;
        @(negedge clk);
        start  = 1'b1;
        parent = '0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL mid_reset_done got=%b want=0", done); end
        total++; if (child !== '0) begin bad++; $display("FAIL mid_reset_child got=%h want=0", child); end
        m_lfsr = 16'hACE1;
        model_run('0, exp, picks);
        run_dut('0, 1'b0, 16'h0, lat, b1, bd);
        total++; if (child !== exp) begin bad++; $display("FAIL mid_reset_rerun got=%h want=%h", child, exp); end
        total++; if (lat != picks + MUT + 1) begin bad++; $display("FAIL mid_reset_latency got=%0d want=%0d", lat, picks + MUT + 1); end
    endtask

`ifdef CGP_MUT_FORCE_CHANGE_EN
    task automatic test_force_change();
        logic [W-1:0] exp;
        int picks, lat;
        logic b1, bd;
        for (int r = 0; r < 100; r++) begin
            model_run('0, exp, picks);
            run_dut('0, 1'b0, 16'h0, lat, b1, bd);
            total++; if (child === '0) begin bad++; $display("FAIL force_unchanged run=%0d got=%h", r, child); end
            total++; if (child !== exp) begin bad++; $display("FAIL force_model run=%0d got=%h want=%h", r, child, exp); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_zero_parent();
        test_random();
        test_repeat_seed();
        test_seed_zero();
        test_start_while_busy();
        test_reset_mid();
`ifdef CGP_MUT_FORCE_CHANGE_EN
        test_force_change();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
